// File: rtl/pe_cmac_if.sv
// rtl/pe_cmac_if.sv - group-in / row-out stream bundle for pe_cmac_engine
interface pe_cmac_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_GATE_QBIT = 2
);
  localparam int DIM = 1 << MAX_GATE_QBIT;

  logic                            i_in_valid;
  logic                            o_in_ready;
  logic [DIM*2*DATA_WIDTH-1:0]     i_in_data;
  logic                            o_out_valid;
  logic                            i_out_ready;
  logic [2*DATA_WIDTH-1:0]         o_out_data;
  logic [MAX_GATE_QBIT-1:0]        o_out_idx;
  logic                            o_out_last;

  modport slave (
    input  i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_data, o_out_idx, o_out_last
  );

  modport master (
    output i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_data, o_out_idx, o_out_last
  );
endinterface

// File: rtl/pe_cmac_engine.sv
// rtl/pe_cmac_engine.sv - k-qubit complex gate apply engine; optional output saturation under PE_CMAC_SAT_EN
module pe_cmac_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_FRAC_BIT  = 30,
  parameter int MAX_GATE_QBIT = 2,
  parameter int GADDR_WIDTH   = 2*MAX_GATE_QBIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               i_gate_qbit,
  input  logic [1:0]               i_op_mode,
  input  logic                     i_gate_we,
  input  logic [GADDR_WIDTH-1:0]   i_gate_addr,
  input  logic [2*DATA_WIDTH-1:0]  i_gate_data,
  pe_cmac_if.slave                 bus,
  output logic                     o_busy,
  output logic                     o_gate_err,
`ifdef PE_CMAC_SAT_EN
  output logic                     o_sat_flag,
`endif
  output logic [15:0]              o_group_cnt
);

  localparam int DIM   = 1 << MAX_GATE_QBIT;
  localparam int NENT  = DIM * DIM;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = 2*DATA_WIDTH + MAX_GATE_QBIT + 1;
  localparam int HI_LO = NUM_FRAC_BIT + DATA_WIDTH - 1;
  localparam int HI_W  = ACC_W - HI_LO;

  localparam logic [DATA_WIDTH-1:0] ONE_FX = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [1:0] K_MAX      = 2'(MAX_GATE_QBIT);
  localparam logic [1:0] MODE_DENSE = 2'd1;
  localparam logic [1:0] MODE_CX    = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [PW-1:0]             r_gate [NENT];
  logic [PW-1:0]             r_amp  [DIM];
  logic [1:0]                r_k;
  logic [1:0]                r_mode;
  logic [MAX_GATE_QBIT-1:0]  r_row;
  logic                      r_out_valid;
  logic [PW-1:0]             r_out_data;
  logic [MAX_GATE_QBIT-1:0]  r_out_idx;
  logic                      r_out_last;
  logic                      r_gate_err;
  logic [15:0]               r_group_cnt;

  logic                      w_accept;
  logic                      w_load;
  logic                      w_done;
  logic                      w_is_last;
  logic [1:0]                w_k_clamped;
  logic [MAX_GATE_QBIT-1:0]  w_last_row;
  logic [MAX_GATE_QBIT-1:0]  w_ctrl_mask;
  logic [MAX_GATE_QBIT-1:0]  w_cx_src;
  logic signed [ACC_W-1:0]   w_acc_re;
  logic signed [ACC_W-1:0]   w_acc_im;
  logic [DATA_WIDTH-1:0]     w_re;
  logic [DATA_WIDTH-1:0]     w_im;
  logic                      w_clip;
  logic [PW-1:0]             w_row_data;
  logic                      w_unused_bits;

  function automatic logic signed [PW-1:0] smul(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] ea;
    logic signed [PW-1:0] eb;
    ea = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    eb = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [PW-1:0] p);
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  // Clamp to the signed DATA_WIDTH range when the bits above the kept window disagree with its sign.
  function automatic logic [DATA_WIDTH:0] sat(input logic [HI_W-1:0] hi,
                                              input logic [DATA_WIDTH-1:0] tr);
    if ((&hi) || !(|hi)) return {1'b0, tr};
    else if (hi[HI_W-1]) return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    else return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction

  assign w_k_clamped = (i_gate_qbit == 2'd0 || i_gate_qbit > K_MAX) ? K_MAX : i_gate_qbit;
  assign w_last_row  = MAX_GATE_QBIT'((32'd1 << r_k) - 32'd1);
  assign w_is_last   = (r_row == w_last_row);

  assign bus.o_in_ready  = (r_state == S_IDLE);
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_data  = r_out_data;
  assign bus.o_out_idx   = r_out_idx;
  assign bus.o_out_last  = r_out_last;
  assign o_busy          = (r_state != S_IDLE);
  assign o_gate_err      = r_gate_err;
  assign o_group_cnt     = r_group_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and the per-cycle accept / row-load / group-done strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_out_valid || bus.i_out_ready) begin
          w_load = 1'b1;
          if (w_is_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.i_out_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Complex multiply-accumulate of the current row against the captured amplitudes.
  always_comb begin
    logic [MAX_GATE_QBIT-1:0] col;
    logic [PW-1:0]            g;
    logic [PW-1:0]            s;
    logic                     use_col;
    w_acc_re = '0;
    w_acc_im = '0;
    for (int c = 0; c < DIM; c++) begin
      col     = MAX_GATE_QBIT'(c);
      g       = r_gate[{r_row, col}];
      s       = r_amp[col];
      use_col = (r_mode == MODE_DENSE) ? (col <= w_last_row) : (col == r_row);
      if (use_col) begin
        w_acc_re = w_acc_re + sx(smul(g[PW-1:DATA_WIDTH], s[PW-1:DATA_WIDTH]))
                            - sx(smul(g[DATA_WIDTH-1:0],  s[DATA_WIDTH-1:0]));
        w_acc_im = w_acc_im + sx(smul(g[PW-1:DATA_WIDTH], s[DATA_WIDTH-1:0]))
                            + sx(smul(g[DATA_WIDTH-1:0],  s[PW-1:DATA_WIDTH]));
      end
    end
  end

  // Fixed-point rescale of the accumulators to the output format.
`ifdef PE_CMAC_SAT_EN
  always_comb begin
    logic [DATA_WIDTH:0] sr;
    logic [DATA_WIDTH:0] si;
    sr     = sat(w_acc_re[ACC_W-1:HI_LO], w_acc_re[NUM_FRAC_BIT +: DATA_WIDTH]);
    si     = sat(w_acc_im[ACC_W-1:HI_LO], w_acc_im[NUM_FRAC_BIT +: DATA_WIDTH]);
    w_re   = sr[DATA_WIDTH-1:0];
    w_im   = si[DATA_WIDTH-1:0];
    w_clip = sr[DATA_WIDTH] | si[DATA_WIDTH];
  end
  assign w_unused_bits = ^{w_acc_re[NUM_FRAC_BIT-1:0], w_acc_im[NUM_FRAC_BIT-1:0]};
`else
  assign w_re   = w_acc_re[NUM_FRAC_BIT +: DATA_WIDTH];
  assign w_im   = w_acc_im[NUM_FRAC_BIT +: DATA_WIDTH];
  assign w_clip = 1'b0;
  // The fractional bits and the wrapped-away high bits are intentionally discarded.
  assign w_unused_bits = ^{w_acc_re[NUM_FRAC_BIT-1:0], w_acc_im[NUM_FRAC_BIT-1:0],
                           w_acc_re[ACC_W-1:NUM_FRAC_BIT+DATA_WIDTH],
                           w_acc_im[ACC_W-1:NUM_FRAC_BIT+DATA_WIDTH], w_clip};
`endif

  // CX source row: target is bit 0, control is bit k-1; with k = 1 the gate degenerates to a plain swap.
  always_comb begin
    w_ctrl_mask = MAX_GATE_QBIT'(1) << (r_k - 2'd1);
    w_cx_src    = r_row;
    if (r_k == 2'd1 || (r_row & w_ctrl_mask) != '0) w_cx_src = r_row ^ MAX_GATE_QBIT'(1);
    w_row_data  = (r_mode == MODE_CX) ? r_amp[w_cx_src] : {w_re, w_im};
  end

  // Gate register file: identity after reset, writable only while idle; dropped writes flag an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NENT; e++)
        r_gate[e] <= ((e / DIM) == (e % DIM)) ? {ONE_FX, {DATA_WIDTH{1'b0}}} : '0;
      r_gate_err <= 1'b0;
    end else begin
      if (i_gate_we && r_state == S_IDLE) r_gate[i_gate_addr] <= i_gate_data;
      r_gate_err <= i_gate_we && (r_state != S_IDLE);
    end
  end

  // Group capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DIM; j++) r_amp[j] <= '0;
      r_k    <= K_MAX;
      r_mode <= 2'd0;
    end else if (w_accept) begin
      for (int j = 0; j < DIM; j++) r_amp[j] <= bus.i_in_data[(j+1)*PW-1 -: PW];
      r_k    <= w_k_clamped;
      r_mode <= i_op_mode;
    end
  end

  // Row counter, output register and completed-group counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_group_cnt <= '0;
    end else begin
      if (w_accept) r_row <= '0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_row_data;
        r_out_idx   <= r_row;
        r_out_last  <= w_is_last;
        r_row       <= r_row + MAX_GATE_QBIT'(1);
      end else if (w_done) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_group_cnt <= r_group_cnt + 16'd1;
      end
    end
  end

`ifdef PE_CMAC_SAT_EN
  logic r_sat_flag;
  assign o_sat_flag = r_sat_flag;

  // Sticky clamp indicator, cleared when a new group is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_sat_flag <= 1'b0;
    else if (w_accept)                           r_sat_flag <= 1'b0;
    else if (w_load && r_mode != MODE_CX && w_clip) r_sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pe_cmac_engine.sv
// tb/tb_pe_cmac_engine.sv - scoreboard bench for pe_cmac_engine
module tb_pe_cmac_engine;
  localparam int DW = 32;
  localparam int FB = 30;
  localparam int MQ = 2;
  localparam int DIM = 4;
  localparam int GW = 4;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    gate_qbit = 2'd1;
  logic [1:0]    op_mode = 2'd0;
  logic          gate_we = 1'b0;
  logic [GW-1:0] gate_addr = '0;
  logic [PW-1:0] gate_data = '0;
  logic          busy;
  logic          gate_err;
  logic [15:0]   group_cnt;
`ifdef PE_CMAC_SAT_EN
  logic          sat_flag;
`endif

  pe_cmac_if #(.DATA_WIDTH(DW), .MAX_GATE_QBIT(MQ)) bus ();

  pe_cmac_engine #(.DATA_WIDTH(DW), .NUM_FRAC_BIT(FB), .MAX_GATE_QBIT(MQ), .GADDR_WIDTH(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_gate_qbit (gate_qbit),
    .i_op_mode   (op_mode),
    .i_gate_we   (gate_we),
    .i_gate_addr (gate_addr),
    .i_gate_data (gate_data),
    .bus         (bus),
    .o_busy      (busy),
    .o_gate_err  (gate_err),
`ifdef PE_CMAC_SAT_EN
    .o_sat_flag  (sat_flag),
`endif
    .o_group_cnt (group_cnt)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_groups = 0;
  logic [63:0] gate_m [16];
  logic [63:0] amp_m  [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] scale(input longint acc);
    longint sh;
    sh = acc >>> FB;
`ifdef PE_CMAC_SAT_EN
    if (sh > 64'sd2147483647) return 32'h7FFFFFFF;
    if (sh < -64'sd2147483648) return 32'h80000000;
`endif
    return sh[31:0];
  endfunction

  function automatic logic [63:0] model_row(input int mode, input int k, input int r);
    longint ar, ai, gr, gi, sr, si;
    int src;
    ar = 0;
    ai = 0;
    if (mode == 2) begin
      src = (k == 1 || r[k-1]) ? (r ^ 1) : r;
      return amp_m[src];
    end
    for (int c = 0; c < (1 << k); c++) begin
      if (mode == 1 || c == r) begin
        gr = longint'($signed(gate_m[r*4+c][63:32]));
        gi = longint'($signed(gate_m[r*4+c][31:0]));
        sr = longint'($signed(amp_m[c][63:32]));
        si = longint'($signed(amp_m[c][31:0]));
        ar += gr*sr - gi*si;
        ai += gr*si + gi*sr;
      end
    end
    return {scale(ar), scale(ai)};
  endfunction

  function automatic logic [31:0] rsmall();
    return 32'(int'($urandom_range(0, 1 << 29)) - (1 << 28));
  endfunction

  task automatic reset_model();
    for (int e = 0; e < 16; e++) gate_m[e] = ((e / 4) == (e % 4)) ? 64'h40000000_00000000 : 64'h0;
  endtask

  task automatic write_gate(input int addr, input logic [63:0] data);
    gate_we = 1'b1;
    gate_addr = 4'(addr);
    gate_data = data;
    @(posedge clk); #1;
    gate_we = 1'b0;
    gate_m[addr] = data;
  endtask

  // Accepts one group; optionally issues a gate write in the accept cycle.
  task automatic send_group(input int mode, input int k_in, input bit do_wr,
                            input int wr_addr, input logic [63:0] wr_data);
    int k;
    logic [255:0] d;
    k = (k_in == 0 || k_in > 2) ? 2 : k_in;
    if (do_wr) gate_m[wr_addr] = wr_data;
    for (int j = 0; j < DIM; j++) d[(j+1)*64-1 -: 64] = amp_m[j];
    for (int r = 0; r < (1 << k); r++)
      exp_q.push_back('{data: model_row(mode, k, r), idx: 2'(r), last: (r == (1 << k) - 1)});
    check("in_ready_idle", {63'h0, bus.o_in_ready}, 64'h1);
    op_mode = 2'(mode);
    gate_qbit = 2'(k_in);
    bus.i_in_data = d;
    bus.i_in_valid = 1'b1;
    gate_we = do_wr;
    gate_addr = 4'(wr_addr);
    gate_data = wr_data;
    @(posedge clk); #1;
    bus.i_in_valid = 1'b0;
    gate_we = 1'b0;
    check("lat0_valid", {63'h0, bus.o_out_valid}, 64'h0);
    check("busy_after_accept", {63'h0, busy}, 64'h1);
    n_groups++;
  endtask

  task automatic wait_done(input bit rnd_ready, output int cycles);
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (rnd_ready) bus.i_out_ready = $urandom_range(0, 1);
      if (!busy && exp_q.size() == 0) break;
    end
    bus.i_out_ready = 1'b1;
    if (cycles >= 400) check("group_timeout", {63'h0, busy}, 64'h0);
  endtask

  // Scoreboard: every handshake pops one expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && bus.o_out_valid && bus.i_out_ready) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", bus.o_out_data, e.data);
        check("out_idx", {62'h0, bus.o_out_idx}, {62'h0, e.idx});
        check("out_last", {63'h0, bus.o_out_last}, {63'h0, e.last});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int mode;
    int k;
    logic [63:0] held_data;
    logic [1:0]  held_idx;

    bus.i_in_valid = 1'b0;
    bus.i_in_data = '0;
    bus.i_out_ready = 1'b1;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'h0, bus.o_in_ready}, 64'h1);
    check("rst_out_valid", {63'h0, bus.o_out_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_gate_err", {63'h0, gate_err}, 64'h0);
    check("rst_group_cnt", {48'h0, group_cnt}, 64'h0);
    check("rst_out_data", bus.o_out_data, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity, dense k=1: outputs equal inputs; group takes 2^k+1 cycles to drain.
    amp_m = '{64'h20000000_00000000, 64'h00000000_10000000, 64'h0, 64'h0};
    send_group(1, 1, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    check("k1_cycles", 64'(cyc), 64'd3);
    check("group_cnt_1", {48'h0, group_cnt}, 64'd1);

    // Hadamard.
    write_gate(0, 64'h2D413CCD_00000000);
    write_gate(1, 64'h2D413CCD_00000000);
    write_gate(4, 64'h2D413CCD_00000000);
    write_gate(5, 64'hD2BEC333_00000000);
    amp_m = '{64'h40000000_00000000, 64'h0, 64'h0, 64'h0};
    send_group(1, 1, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);

    // CX, k=2.
    for (int j = 0; j < 4; j++) amp_m[j] = {32'(j + 1), 32'h0};
    send_group(2, 2, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    check("k2_cycles", 64'(cyc), 64'd5);

    // Random dense gate for the remaining multiply tests.
    for (int e = 0; e < 16; e++) write_gate(e, {rsmall(), rsmall()});

    // Stall for 5 cycles on row 0.
    for (int j = 0; j < 4; j++) amp_m[j] = {rsmall(), rsmall()};
    bus.i_out_ready = 1'b0;
    send_group(1, 2, 1'b0, 0, 64'h0);
    @(posedge clk); #1;
    check("lat1_valid", {63'h0, bus.o_out_valid}, 64'h1);
    held_data = bus.o_out_data;
    held_idx = bus.o_out_idx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", bus.o_out_data, held_data);
      check("stall_idx", {62'h0, bus.o_out_idx}, {62'h0, held_idx});
      check("stall_in_ready", {63'h0, bus.o_in_ready}, 64'h0);
    end
    @(posedge clk); #1;
    bus.i_out_ready = 1'b1;
    wait_done(1'b0, cyc);

    // Gate write while busy is dropped and flagged.
    for (int j = 0; j < 4; j++) amp_m[j] = {rsmall(), rsmall()};
    bus.i_out_ready = 1'b0;
    send_group(1, 1, 1'b0, 0, 64'h0);
    gate_we = 1'b1;
    gate_addr = 4'd0;
    gate_data = 64'h20000000_00000000;
    @(posedge clk); #1;
    gate_we = 1'b0;
    @(negedge clk);
    check("gate_err_pulse", {63'h0, gate_err}, 64'h1);
    @(negedge clk);
    check("gate_err_clear", {63'h0, gate_err}, 64'h0);
    @(posedge clk); #1;
    bus.i_out_ready = 1'b1;
    wait_done(1'b0, cyc);
    send_group(1, 1, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);

    // Write in the accept cycle is used by that group.
    send_group(1, 1, 1'b1, 1, 64'h20000000_10000000);
    wait_done(1'b0, cyc);

    // Diagonal, reserved mode, and k clamping.
    for (int j = 0; j < 4; j++) amp_m[j] = {rsmall(), rsmall()};
    send_group(0, 2, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    send_group(3, 2, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    send_group(1, 0, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    check("k0_clamp_cycles", 64'(cyc), 64'd5);
    send_group(2, 3, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);

    // Random modes with random backpressure.
    for (int g = 0; g < 6; g++) begin
      for (int j = 0; j < 4; j++) amp_m[j] = {rsmall(), rsmall()};
      mode = $urandom_range(0, 3);
      k = (mode == 2) ? 2 : $urandom_range(1, 2);
      send_group(mode, k, 1'b0, 0, 64'h0);
      wait_done(1'b1, cyc);
    end
    check("group_cnt_total", {48'h0, group_cnt}, 64'(n_groups));
`ifdef PE_CMAC_SAT_EN
    check("sat_flag_clear", {63'h0, sat_flag}, 64'h0);
`endif

    // Overflow: 1.99 * 1.99 saturates or wraps depending on the build.
    write_gate(0, 64'h7F5C28F6_00000000);
    write_gate(5, 64'h40000000_00000000);
    amp_m = '{64'h7F5C28F6_00000000, 64'h0, 64'h0, 64'h0};
    send_group(0, 1, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
`ifdef PE_CMAC_SAT_EN
    check("sat_flag_set", {63'h0, sat_flag}, 64'h1);
`endif

    // Reset in the middle of a group.
    for (int j = 0; j < 4; j++) amp_m[j] = {rsmall(), rsmall()};
    bus.i_out_ready = 1'b0;
    send_group(1, 2, 1'b0, 0, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'h0, bus.o_out_valid}, 64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_in_ready", {63'h0, bus.o_in_ready}, 64'h1);
    check("midrst_group_cnt", {48'h0, group_cnt}, 64'h0);
    exp_q.delete();
    reset_model();
    n_groups = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_out_ready = 1'b1;
    @(posedge clk); #1;
    send_group(1, 2, 1'b0, 0, 64'h0);
    wait_done(1'b0, cyc);
    check("post_rst_group_cnt", {48'h0, group_cnt}, 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
